// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter: two-port round-robin arbiter in front of the SDRAM
// controller's native RAM port. Ownership is locked for a whole burst and is
// held until every forwarded beat has been acknowledged.
//
// Ports:
//   clk, rst             single clock, synchronous active-high reset
//   m0_* / m1_*          requester ports (wr strobes, rd, len, addr, wdata in;
//                        accept, ack, error, read_data out)
//   ram_*                controller-facing native port
//   owner_o              current or last owner
//   busy_o               arbiter not idle
//   protocol_err_o       sticky: ack seen with nothing outstanding
module sdram_port_arbiter #(
   parameter int unsigned MAX_OUTSTANDING = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  m0_wr_i,
   input  logic        m0_rd_i,
   input  logic [7:0]  m0_len_i,
   input  logic [31:0] m0_addr_i,
   input  logic [31:0] m0_write_data_i,
   output logic        m0_accept_o,
   output logic        m0_ack_o,
   output logic        m0_error_o,
   output logic [31:0] m0_read_data_o,
   input  logic [3:0]  m1_wr_i,
   input  logic        m1_rd_i,
   input  logic [7:0]  m1_len_i,
   input  logic [31:0] m1_addr_i,
   input  logic [31:0] m1_write_data_i,
   output logic        m1_accept_o,
   output logic        m1_ack_o,
   output logic        m1_error_o,
   output logic [31:0] m1_read_data_o,
   output logic [3:0]  ram_wr_o,
   output logic        ram_rd_o,
   output logic [7:0]  ram_len_o,
   output logic [31:0] ram_addr_o,
   output logic [31:0] ram_write_data_o,
   input  logic        ram_accept_i,
   input  logic        ram_ack_i,
   input  logic        ram_error_i,
   input  logic [31:0] ram_read_data_i,
   output logic        owner_o,
   output logic        busy_o,
   output logic        protocol_err_o
);

   localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
   localparam int unsigned LEN_W = 8;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_BUSY,
      ST_DRAIN
   } state_e;

   state_e             state_q, state_d;
   logic               owner_q, owner_d;
   logic               last_grant_q, last_grant_d;
   logic [LEN_W-1:0]   len_q, len_d;
   logic [LEN_W-1:0]   beat_q, beat_d;
   logic [CNT_W-1:0]   outst_q, outst_d;
   logic               prot_err_q, prot_err_d;

   logic               req0, req1, grant;
   logic               fwd_en, fwd_acc, ack_ok;
   logic [3:0]         own_wr;
   logic               own_rd;
   logic [31:0]        own_addr, own_wdata;

   // State register; last_grant resets to 1 so port 0 wins the first tie.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         owner_q      <= 1'b0;
         last_grant_q <= 1'b1;
         len_q        <= '0;
         beat_q       <= '0;
         outst_q      <= '0;
         prot_err_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         last_grant_q <= last_grant_d;
         len_q        <= len_d;
         beat_q       <= beat_d;
         outst_q      <= outst_d;
         prot_err_q   <= prot_err_d;
      end
   end

   // Arbitration, burst tracking, outstanding accounting and port muxing.
   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      last_grant_d = last_grant_q;
      len_d        = len_q;
      beat_d       = beat_q;
      outst_d      = outst_q;
      prot_err_d   = prot_err_q;
      grant        = 1'b0;

      req0 = (m0_wr_i != 4'd0) | m0_rd_i;
      req1 = (m1_wr_i != 4'd0) | m1_rd_i;

      own_wr    = owner_q ? m1_wr_i         : m0_wr_i;
      own_rd    = owner_q ? m1_rd_i         : m0_rd_i;
      own_addr  = owner_q ? m1_addr_i       : m0_addr_i;
      own_wdata = owner_q ? m1_write_data_i : m0_write_data_i;

      // Forwarding stops at the outstanding cap so the counter cannot wrap.
      fwd_en  = (state_q == ST_BUSY) && (outst_q != CNT_W'(MAX_OUTSTANDING));
      fwd_acc = fwd_en & ram_accept_i;
      // An ack with nothing outstanding is dropped and flagged.
      ack_ok  = ram_ack_i & (outst_q != '0);

      if (fwd_acc && !ack_ok) begin
         outst_d = outst_q + CNT_W'(1);
      end else if (!fwd_acc && ack_ok) begin
         outst_d = outst_q - CNT_W'(1);
      end
      if (ram_ack_i && (outst_q == '0)) begin
         prot_err_d = 1'b1;
      end

      case (state_q)
         ST_IDLE: begin
            if (req0 || req1) begin
               grant   = (req0 && req1) ? ~last_grant_q : req1;
               owner_d = grant;
               len_d   = grant ? m1_len_i : m0_len_i;
               beat_d  = '0;
               state_d = ST_BUSY;
            end
         end
         ST_BUSY: begin
            if (fwd_acc) begin
               beat_d = beat_q + LEN_W'(1);
               if (beat_q == len_q) begin
                  state_d = ST_DRAIN;
               end
            end
         end
         ST_DRAIN: begin
            // Uses the next count so a same-cycle final ack releases at once.
            if (outst_d == '0) begin
               state_d      = ST_IDLE;
               last_grant_d = owner_q;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      ram_wr_o         = fwd_en ? own_wr    : 4'd0;
      ram_rd_o         = fwd_en ? own_rd    : 1'b0;
      ram_addr_o       = fwd_en ? own_addr  : 32'd0;
      ram_write_data_o = fwd_en ? own_wdata : 32'd0;
      ram_len_o        = len_q;

      m0_accept_o    = fwd_acc & ~owner_q;
      m1_accept_o    = fwd_acc & owner_q;
      m0_ack_o       = ack_ok & ~owner_q;
      m1_ack_o       = ack_ok & owner_q;
      m0_error_o     = ack_ok & ram_error_i & ~owner_q;
      m1_error_o     = ack_ok & ram_error_i & owner_q;
      m0_read_data_o = ram_read_data_i;
      m1_read_data_o = ram_read_data_i;

      owner_o        = owner_q;
      busy_o         = (state_q != ST_IDLE);
      protocol_err_o = prot_err_q;
   end

endmodule
